// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and elaboration helpers for chunked_serial_adder.
// Optional feature macro: CHUNKED_ADDER_SIGNED_OVF_EN (adds the ovf output).
package chunked_serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Counter width for n states; never below one bit so NCHUNK == 1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // CHUNK must lie in 1..WIDTH and divide WIDTH exactly.
    function automatic bit chunk_legal(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells. Also exposes the carry into the
// top bit so the parent can derive signed overflow on the final chunk.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock, carrying between
// chunks through a register. valid/ready handshake on both sides, no operation overlap.
// Optional feature macro: CHUNKED_ADDER_SIGNED_OVF_EN (adds the ovf output).
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam bit              ChunkLegal = chunk_legal(WIDTH, CHUNK);
    localparam int unsigned     NCHUNK     = WIDTH / CHUNK;
    localparam int unsigned     CntW       = cnt_width(NCHUNK);
    localparam logic [CntW-1:0] LastCnt    = CntW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

    if (!ChunkLegal) begin : g_bad_chunk
        $error("chunked_serial_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic             chunk_cmsb;

    // Select the operand slice for the chunk currently being added.
    always_comb begin
        base    = 32'(cnt_q) * CHUNK;
        a_chunk = CHUNK'(a_q >> base);
        b_chunk = CHUNK'(b_q >> base);
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .s_o    (chunk_s),
        .cout_o (chunk_cout),
        .cmsb_o (chunk_cmsb)
    );

`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    logic ovf_q;

    // Signed overflow is taken from the top bit's carries on the final chunk only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StCalc && cnt_q == LastCnt) begin
            ovf_q <= chunk_cmsb ^ chunk_cout;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = chunk_cmsb;
`endif

    // Control FSM with registered handshake outputs and the chunked datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    sum_q   <= (sum_q & ~(ChunkMask << base)) | (WIDTH'(chunk_s) << base);
                    carry_q <= chunk_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        cout_q      <= chunk_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // in_ready stays low through the handshake cycle: no overlap.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
Parametrised multi-cycle adder that adds two WIDTH-bit operands CHUNK bits per clock. It keeps a registered carry between chunks.
- Successor to the single-bit combinational full adder: generalised in width and in datapath slice width, with a valid/ready handshake on both sides.
- Sits between operand sources and result consumers where area matters more than single-cycle latency.

Parameters:
- WIDTH, 32: operand and sum width in bits.
- CHUNK, 4: bits added per cycle. Legal range 1..WIDTH. WIDTH % CHUNK == 0 is required; elaboration error otherwise.
- NCHUNK, WIDTH/CHUNK (derived localparam): number of add cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result (a+b+cin) mod 2^WIDTH
- cout  out  1  carry-out of MSB
- ovf  out  1  signed overflow (present only with macro; see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and takes priority over every other event.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk counter=0, carry register=0.
- FSM states IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b; carry register <= cin; counter <= 0; sum <= 0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, chunk k = counter computes {c, s} = a[k*CHUNK +: CHUNK] + b[k*CHUNK +: CHUNK] + carry.
  - sum[k*CHUNK +: CHUNK] <= s; carry <= c; counter++.
  - When counter == NCHUNK-1: cout <= c, go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are held stable until out_ready=1.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
- Latency: operands are accepted at edge T. out_valid rises at edge T+NCHUNK.
  - CHUNK=WIDTH gives a 1-cycle result.
  - CHUNK=1 gives a WIDTH-cycle result.
- Throughput: one operation per NCHUNK+2 cycles minimum. in_ready is low in DONE, even during the handshake cycle, so there is no overlap.
- Operand stability: a, b and cin are sampled only at acceptance. Input changes after acceptance have no effect.
- Arithmetic:
  - Unsigned modular; no saturation.
  - The carry chain crosses chunk boundaries only through the carry register.
  - Wrap-around: 0xFF..F + 1 gives sum 0, cout 1.
- Simultaneous events:
  - rst asserted together with in_valid or out_ready: reset wins and the operation is discarded.
  - in_valid asserted while not in IDLE: ignored, with no side effects.
- Reset mid-operation: the FSM returns to IDLE next edge. The partial sum is cleared and out_valid is never asserted for that operation.
- sum bits above the current chunk may read as partial during CALC. Consumers must use sum only when out_valid=1.

Optional Feature:
- Macro CHUNKED_ADDER_SIGNED_OVF_EN.
- Defined: ovf port exists. At the final chunk, ovf <= c_into_msb ^ c_out_of_msb, where c_into_msb is the carry into bit WIDTH-1. ovf is held in DONE and cleared on reset.
- Undefined: ovf port and its logic are absent, and the port list ends at cout.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, CALC, DONE);
  - a clog2-based counter-width helper;
  - the WIDTH/CHUNK legality check constant.
- One natural sub-module: chunk_adder, a combinational CHUNK-bit ripple of full-adder cells. Inputs are a, b and cin. Outputs are s, cout and carry-into-MSB, used for ovf.

Test Plan:
1. WIDTH=8, CHUNK=4, a=0x3C, b=0x45, cin=0 -> sum=0x81, cout=0, ovf=1. out_valid rises exactly 2 cycles after acceptance.
2. WIDTH=8, CHUNK=4, a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0 (wrap-around).
3. WIDTH=8, CHUNK=4, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also run with the macro undefined: the ovf port must be absent.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE. sum and cout must stay stable, in_ready=0 throughout, and in_valid pulses in that window must be ignored.
5. Assert rst one cycle into CALC with a=0xAA, b=0x55. Next edge: IDLE, in_ready=1, sum=0, out_valid never rises. A new op 0x01+0x01 must then give 0x02.
6. Parameter sweep at WIDTH=16, CHUNK in {1, 4, 16}, random a/b/cin, compared against a reference model. Latency must equal 16, 4 and 1 cycles respectively.
